// File: rtl/proc_sequencer_pkg.sv
// Shared ISA constants and sequencer state encoding for the 8-bit accumulator processor.
package proc_sequencer_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 8;
  localparam int unsigned OPCODE_BITS       = 3;

  localparam logic [OPCODE_BITS-1:0] OP_NOP = 3'd0;
  localparam logic [OPCODE_BITS-1:0] OP_LD  = 3'd1;
  localparam logic [OPCODE_BITS-1:0] OP_ST  = 3'd2;
  localparam logic [OPCODE_BITS-1:0] OP_ADD = 3'd3;
  localparam logic [OPCODE_BITS-1:0] OP_SUB = 3'd4;
  localparam logic [OPCODE_BITS-1:0] OP_JMP = 3'd5;
  localparam logic [OPCODE_BITS-1:0] OP_JC  = 3'd6;
  localparam logic [OPCODE_BITS-1:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/proc_sequencer_if.sv
// Sequencer <-> ROM/ID/datapath bundle; master is the sequencer side.
interface proc_sequencer_if
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = INSTRUCTION_WIDTH,
  parameter int unsigned PC_WIDTH    = 5
);
  logic [INSTR_WIDTH-1:0] rom_data;
  logic                   id_ld_ce;
  logic                   id_st_ce;
  logic                   id_acc_ce;
  logic                   id_cy_ce;
  logic                   cy;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   ld_ce;
  logic                   st_ce;
  logic                   acc_ce;
  logic                   cy_ce;
  logic                   pc_ce;
  logic                   pc_load;
  logic [PC_WIDTH-1:0]    pc_target;

  modport master (
    input  rom_data, id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, cy,
    output instr, ld_ce, st_ce, acc_ce, cy_ce, pc_ce, pc_load, pc_target
  );

  modport slave (
    output rom_data, id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, cy,
    input  instr, ld_ce, st_ce, acc_ce, cy_ce, pc_ce, pc_load, pc_target
  );
endinterface

// File: rtl/proc_sequencer_seq_run_ctrl.sv
// Run/stop/single-step control: decides when to leave HALT and whether to chain the next instruction.
module seq_run_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic in_halt,
  input  logic in_wb,
  input  logic wb_hlt,
  output logic go,
  output logic cont,
  output logic run_mode,
  output logic stop_pend
);
  logic run_mode_q, run_mode_d;
  logic stop_pend_q, stop_pend_d;
  logic eff_stop;

  always_comb begin
    // A start seen while running cancels an earlier stop, but a same-cycle stop still wins.
    eff_stop    = stop | (stop_pend_q & ~start);
    go          = in_halt & (step | (start & ~stop));
    cont        = in_wb & run_mode_q & ~eff_stop & ~wb_hlt;
    run_mode_d  = run_mode_q;
    stop_pend_d = stop_pend_q;
    if (in_halt) begin
      run_mode_d  = start & ~stop;
      stop_pend_d = 1'b0;
    end else if (in_wb) begin
      run_mode_d  = cont;
      stop_pend_d = 1'b0;
    end else if (stop) begin
      stop_pend_d = 1'b1;
    end else if (start) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mode_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      run_mode_q  <= run_mode_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign run_mode  = run_mode_q;
  assign stop_pend = stop_pend_q;
endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit: owns the IR, phase-gates ID enables, steers the PC.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH  = INSTRUCTION_WIDTH,
  parameter int unsigned OPCODE_WIDTH = OPCODE_BITS,
  parameter int unsigned PC_WIDTH     = 5,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  proc_sequencer_if.master     bus,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);
  seq_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic go, cont, run_mode, stop_pend;

  assign opcode = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  seq_run_ctrl u_run_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .in_halt   (state_q == S_HALT),
    .in_wb     (state_q == S_WB),
    .wb_hlt    (opcode == OPCODE_WIDTH'(OP_HLT)),
    .go        (go),
    .cont      (cont),
    .run_mode  (run_mode),
    .stop_pend (stop_pend)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_HALT:   if (go) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = bus.rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = cont ? S_FETCH : S_HALT;
      end
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HALT;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Enables are gated purely by phase so each instruction gets exactly one write window.
  always_comb begin
    bus.ld_ce   = 1'b0;
    bus.acc_ce  = 1'b0;
    bus.cy_ce   = 1'b0;
    bus.st_ce   = 1'b0;
    bus.pc_ce   = 1'b0;
    bus.pc_load = 1'b0;
    case (state_q)
      S_EXEC: begin
        bus.ld_ce  = bus.id_ld_ce;
        bus.acc_ce = bus.id_acc_ce;
        bus.cy_ce  = bus.id_cy_ce;
      end
      S_WB: begin
        bus.st_ce   = bus.id_st_ce;
        bus.pc_ce   = 1'b1;
        bus.pc_load = (opcode == OPCODE_WIDTH'(OP_JMP)) |
                      ((opcode == OPCODE_WIDTH'(OP_JC)) & bus.cy);
      end
      default: ;
    endcase
  end

  assign bus.instr     = ir_q;
  assign bus.pc_target = ir_q[PC_WIDTH-1:0];
  assign halted        = (state_q == S_HALT);
  assign state         = state_q;
  assign retired       = retired_q;
endmodule

// File: tb/tb_proc_sequencer.sv
// Directed + randomized bench for proc_sequencer with an instruction-level reference model.
module tb_proc_sequencer;
  import proc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, step = 1'b0;
  logic halted;
  logic [2:0] state;
  logic [15:0] retired;

  logic w_start = 1'b0, w_stop = 1'b0;
  logic w_halted;
  logic [2:0] w_state;
  logic [2:0] w_retired;

  int total = 0;
  int bad = 0;

  logic [7:0] rom [32];
  logic [4:0] pc;

  logic [4:0]  m_pc = '0;
  logic [15:0] m_retired = '0;
  bit          m_run = 1'b0;

  always #5 clk = ~clk;

  proc_sequencer_if #(.INSTR_WIDTH(8), .PC_WIDTH(5)) bus ();
  proc_sequencer_if #(.INSTR_WIDTH(8), .PC_WIDTH(5)) w_bus ();

  proc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .bus(bus), .halted(halted), .state(state), .retired(retired)
  );

  proc_sequencer #(.CNT_WIDTH(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .stop(w_stop), .step(1'b0),
    .bus(w_bus), .halted(w_halted), .state(w_state), .retired(w_retired)
  );

  // {ld, st, acc, cy} produced by the instruction decoder stub
  function automatic logic [3:0] id_of(input logic [2:0] op);
    case (op)
      OP_LD:          return 4'b1010;
      OP_ST:          return 4'b0100;
      OP_ADD, OP_SUB: return 4'b0011;
      default:        return 4'b0000;
    endcase
  endfunction

  assign {bus.id_ld_ce, bus.id_st_ce, bus.id_acc_ce, bus.id_cy_ce} = id_of(bus.instr[7:5]);
  assign bus.rom_data = rom[pc];
  assign w_bus.rom_data  = '0;
  assign w_bus.id_ld_ce  = 1'b0;
  assign w_bus.id_st_ce  = 1'b0;
  assign w_bus.id_acc_ce = 1'b0;
  assign w_bus.id_cy_ce  = 1'b0;
  assign w_bus.cy        = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc <= '0;
    else if (bus.pc_ce)  pc <= bus.pc_load ? bus.pc_target : pc + 5'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ens();
    return {bus.ld_ce, bus.acc_ce, bus.cy_ce, bus.st_ce, bus.pc_ce, bus.pc_load};
  endfunction

  task automatic pulse_start();
    start = 1'b1; m_run = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
  endtask

  // One instruction from FETCH to the edge after WB; cy_sel 0/1 forces cy, 2 randomizes it.
  task automatic run_instr(input bit stop_dec, input bit noise, input int cy_sel);
    logic [7:0] w;
    logic [2:0] op;
    logic [3:0] idv;
    logic c, ld;
    bit cont;
    w = rom[m_pc]; op = w[7:5]; idv = id_of(op);
    @(negedge clk);
    check("fetch_state", 32'(state), 32'd1);
    check("fetch_en", 32'(ens()), 32'd0);
    @(posedge clk); #1;
    if (stop_dec) stop = 1'b1;
    if (noise) step = 1'b1;
    @(negedge clk);
    check("decode_state", 32'(state), 32'd2);
    check("decode_ir", 32'(bus.instr), 32'(w));
    check("decode_en", 32'(ens()), 32'd0);
    @(posedge clk); #1; stop = 1'b0; step = 1'b0;
    @(negedge clk);
    check("exec_state", 32'(state), 32'd3);
    check("exec_en", 32'(ens()), 32'({idv[3], idv[1], idv[0], 3'b000}));
    @(posedge clk); #1;
    c = (cy_sel == 2) ? 1'($urandom_range(0, 1)) : cy_sel[0];
    bus.cy = c;
    ld = (op == OP_JMP) || (op == OP_JC && c);
    @(negedge clk);
    check("wb_state", 32'(state), 32'd4);
    check("wb_en", 32'(ens()), 32'({3'b000, idv[2], 1'b1, ld}));
    check("wb_target", 32'(bus.pc_target), 32'(w[4:0]));
    check("wb_retired", 32'(retired), 32'(m_retired));
    m_pc = ld ? w[4:0] : m_pc + 5'd1;
    m_retired = m_retired + 16'd1;
    cont = m_run && !stop_dec && (op != OP_HLT);
    m_run = cont;
    @(posedge clk); #1;
    check("post_retired", 32'(retired), 32'(m_retired));
    check("post_pc", 32'(pc), 32'(m_pc));
    check("post_halted", 32'(halted), 32'(!cont));
    check("post_state", 32'(state), cont ? 32'd1 : 32'd0);
  endtask

  initial begin
    bus.cy = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // reset state, idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_halted", 32'(halted), 32'd1);
      check("rst_state", 32'(state), 32'd0);
      check("rst_en", 32'(ens()), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'd0);
    end
    @(posedge clk); #1;

    // LD/ADD/ST/HLT program
    rom[0] = 8'h21; rom[1] = 8'h62; rom[2] = 8'h43; rom[3] = 8'hE0;
    pulse_start();
    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 0);
    check("prog_retired", 32'(retired), 32'd4);
    check("prog_pc", 32'(pc), 32'd4);

    // JMP to 0x10
    rom[4] = 8'hB0; rom[16] = 8'hE0;
    pulse_start();
    run_instr(1'b0, 1'b0, 0);
    check("jmp_pc", 32'(pc), 32'h10);
    run_instr(1'b0, 1'b0, 2);

    // JC not taken, then taken to 3 (HLT)
    rom[17] = 8'hC3; rom[18] = 8'hC3;
    pulse_start();
    run_instr(1'b0, 1'b0, 0);
    check("jc0_pc", 32'(pc), 32'd18);
    run_instr(1'b0, 1'b0, 1);
    check("jc1_pc", 32'(pc), 32'd3);
    run_instr(1'b0, 1'b0, 2);

    // single-step x3 with stray step pulses mid-instruction
    rom[4] = 8'h21; rom[5] = 8'h62; rom[6] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      run_instr(1'b0, 1'b1, 2);
      @(negedge clk);
      check("step_idle_halted", 32'(halted), 32'd1);
      @(posedge clk); #1;
    end
    check("step_retired", 32'(retired), 32'd12);

    // stop during DECODE completes the instruction then halts
    rom[7] = 8'h00; rom[8] = 8'h43;
    pulse_start();
    run_instr(1'b1, 1'b0, 2);
    @(negedge clk);
    check("stop_idle_halted", 32'(halted), 32'd1);
    @(posedge clk); #1;

    // reset during EXEC of a ST aborts it
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_exec_state", 32'(state), 32'd3);
    rst_n = 1'b0; #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_st", 32'(bus.st_ce), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    m_pc = '0; m_retired = '0; m_run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_idle_en", 32'(ens()), 32'd0);
      check("abort_idle_ret", 32'(retired), 32'd0);
      check("abort_idle_pc", 32'(pc), 32'd0);
    end
    @(posedge clk); #1;

    // randomized programs, cy and stop requests
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      if (!m_run) pulse_start();
      run_instr($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 2);
    end
    if (m_run) begin
      stop = 1'b1; m_run = 1'b0;
      repeat (4) begin @(posedge clk); #1; stop = 1'b0; end
      @(negedge clk);
      check("rand_final_halted", 32'(halted), 32'd1);
      m_retired = m_retired + 16'd1;
      check("rand_final_ret", 32'(retired), 32'(m_retired));
      @(posedge clk); #1;
    end

    // retired counter wrap on a narrow instance
    w_start = 1'b1;
    @(posedge clk); #1; w_start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) w_stop = 1'b1;
      @(posedge clk); #1; w_stop = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("wrap_retired", 32'(w_retired), 32'(i % 8));
    end
    @(negedge clk);
    check("wrap_halted", 32'(w_halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
